onehot_rr_arbiter8: RTL and testbench

Upstream request stage for the 8-to-3 encoder. It captures rising-edge events on eight request lines into a pending register and arbitrates among them round-robin. It presents one winner at a time as a registered one-hot word with a valid/ready handshake. `grant_onehot` connects directly to the encoder data input and `grant_valid` to its enable, so the encoder only sees one-hot or all-zero input.

---
 rtl/onehot_rr_arbiter8.sv | 90 +++++++++
 tb/tb_onehot_rr_arbiter8.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_arbiter8.sv
// Eight-way rising-edge request capture with round-robin arbitration.
// Presents one registered one-hot winner at a time behind a valid/ready handshake.
module onehot_rr_arbiter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       grant_ready,
  input  logic       clr_overrun,
  output logic [7:0] grant_onehot,
  output logic       grant_valid,
  output logic [7:0] pending,
  output logic [7:0] overrun
);

  logic [7:0] req_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] gnt_q, gnt_d;
  logic [7:0] ovr_q, ovr_d;
  logic       vld_q, vld_d;
  logic [2:0] ptr_q, ptr_d;

  logic [7:0] rise;
  logic [7:0] win_oh;
  logic [7:0] load_oh;
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic       load;

  assign rise = req & ~req_q;

  // Round-robin search: first pending bit at or after ptr, wrapping mod 8.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + i[2:0];
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_oh  = 8'b1 << win;
  assign load    = found && (!vld_q || grant_ready);
  assign load_oh = load ? win_oh : 8'h00;

  always_comb begin
    // A rise on the bit being loaded re-sets it, so that event is kept.
    pend_d = (pend_q & ~load_oh) | rise;
    ovr_d  = (clr_overrun ? 8'h00 : ovr_q) | (rise & pend_q & ~load_oh);
    gnt_d  = gnt_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (load) begin
      gnt_d = win_oh;
      vld_d = 1'b1;
      ptr_d = win + 3'd1;
    end else if (vld_q && grant_ready) begin
      gnt_d = 8'h00;
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= '0;
      pend_q <= '0;
      gnt_q  <= '0;
      ovr_q  <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      req_q  <= req;
      pend_q <= pend_d;
      gnt_q  <= gnt_d;
      ovr_q  <= ovr_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign grant_onehot = gnt_q;
  assign grant_valid  = vld_q;
  assign pending      = pend_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_onehot_rr_arbiter8.sv
// Directed bench for onehot_rr_arbiter8: expected grants queued at stimulus time,
// compared as each grant is accepted.
module tb_onehot_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       grant_ready = 1'b1;
  logic       clr_overrun = 1'b0;
  logic [7:0] grant_onehot;
  logic       grant_valid;
  logic [7:0] pending;
  logic [7:0] overrun;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  sb_q[$];

  onehot_rr_arbiter8 dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant_ready  (grant_ready),
    .clr_overrun  (clr_overrun),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .pending      (pending),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grants are accepted on the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    chk("onehot_inv", grant_onehot & (grant_onehot - 8'd1), 32'd0);
    chk("zero_idle", grant_valid ? 8'h00 : grant_onehot, 32'd0);
    if (!rst && grant_valid && grant_ready) begin
      if (sb_q.size() == 0) chk("sb_extra", grant_onehot, 32'd0);
      else                  chk("sb_grant", grant_onehot, sb_q.pop_front());
    end
  end

  initial begin
    // Reset values before any clock edge
    #1;
    chk("rst_gnt", grant_onehot, 0);
    chk("rst_vld", grant_valid, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ovr", overrun, 0);
    tick(); tick();
    rst = 1'b0;

    // Single event on bit 4
    req = 8'h10; sb_q.push_back(8'h10);
    tick();
    chk("t1_pend", pending, 8'h10);
    chk("t1_vld0", grant_valid, 0);
    req = 8'h00;
    tick();
    chk("t1_gnt", grant_onehot, 8'h10);
    chk("t1_vld1", grant_valid, 1);
    chk("t1_pend0", pending, 0);
    tick();
    chk("t1_vld_end", grant_valid, 0);
    chk("t1_gnt_end", grant_onehot, 0);

    // Round-robin order from ptr=0 and wrap
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 8; i++) sb_q.push_back(8'h01 << i);
    tick();
    req = 8'h00;
    chk("t2_pend", pending, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_vld", grant_valid, 1);
    end
    tick();
    chk("t2_vld_end", grant_valid, 0);
    req = 8'h81; sb_q.push_back(8'h01); sb_q.push_back(8'h80);
    tick();
    req = 8'h00;
    tick();
    chk("t2_wrap_a", grant_onehot, 8'h01);
    tick();
    chk("t2_wrap_b", grant_onehot, 8'h80);
    tick();
    chk("t2_wrap_end", grant_valid, 0);

    // Backpressure hold
    grant_ready = 1'b0;
    req = 8'h06; sb_q.push_back(8'h02); sb_q.push_back(8'h04);
    tick();
    req = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_gnt", grant_onehot, 8'h02);
      chk("t3_hold_pend", pending, 8'h04);
      tick();
    end
    grant_ready = 1'b1;
    tick();
    chk("t3_gnt2", grant_onehot, 8'h04);
    chk("t3_pend0", pending, 0);
    tick();
    chk("t3_vld_end", grant_valid, 0);

    // Overrun on bit 3 while grant on bit 0 is held
    grant_ready = 1'b0;
    req = 8'h01; sb_q.push_back(8'h01);
    tick();
    req = 8'h00;
    tick();
    req = 8'h08; tick(); req = 8'h00; tick();
    req = 8'h08; tick(); req = 8'h00;
    chk("t4_ovr", overrun, 8'h08);
    chk("t4_pend", pending, 8'h08);
    chk("t4_gnt", grant_onehot, 8'h01);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    chk("t4_clr", overrun, 0);
    chk("t4_pend_kept", pending, 8'h08);
    clr_overrun = 1'b1; req = 8'h08; tick();
    clr_overrun = 1'b0; req = 8'h00;
    chk("t4_clr_vs_set", overrun, 8'h08);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    chk("t4_clr2", overrun, 0);
    grant_ready = 1'b1; sb_q.push_back(8'h08);
    tick();
    chk("t4_gnt3", grant_onehot, 8'h08);
    chk("t4_pend0", pending, 0);
    tick();
    chk("t4_vld_end", grant_valid, 0);

    // Same-edge load and re-request on bit 5
    grant_ready = 1'b0;
    req = 8'h10; sb_q.push_back(8'h10);
    tick();
    req = 8'h00;
    tick();
    req = 8'h20; tick(); req = 8'h00; tick();
    chk("t5_pend_pre", pending, 8'h20);
    chk("t5_gnt_pre", grant_onehot, 8'h10);
    grant_ready = 1'b1; req = 8'h20;
    sb_q.push_back(8'h20); sb_q.push_back(8'h20);
    tick();
    req = 8'h00;
    chk("t5_gnt", grant_onehot, 8'h20);
    chk("t5_pend", pending, 8'h20);
    chk("t5_ovr", overrun, 0);
    tick();
    chk("t5_gnt2", grant_onehot, 8'h20);
    chk("t5_pend0", pending, 0);
    tick();
    chk("t5_vld_end", grant_valid, 0);

    // Async reset mid-stream
    grant_ready = 1'b0;
    req = 8'h01; tick(); req = 8'h00; tick();
    req = 8'hF0; tick(); req = 8'h00; tick();
    chk("t6_pend", pending, 8'hF0);
    chk("t6_vld", grant_valid, 1);
    req = 8'h80; tick(); req = 8'h00; tick();
    chk("t6_ovr", overrun, 8'h80);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_gnt", grant_onehot, 0);
    chk("t6_rst_vld", grant_valid, 0);
    chk("t6_rst_pend", pending, 0);
    chk("t6_rst_ovr", overrun, 0);
    tick(); tick();
    grant_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_idle", grant_valid, 0);
    end
    req = 8'h04; sb_q.push_back(8'h04);
    tick();
    req = 8'h00;
    chk("t6_lat_pend", pending, 8'h04);
    chk("t6_lat_vld0", grant_valid, 0);
    tick();
    chk("t6_lat_vld1", grant_valid, 1);
    chk("t6_lat_gnt", grant_onehot, 8'h04);
    tick();
    chk("t6_vld_end", grant_valid, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
